// File: rtl/cache_pkg.sv
// Shared FSM encoding, width helper and address field macro for the N-way write-back cache.
package cache_pkg;

  localparam int unsigned ST_W = 3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOOKUP = 3'd1;
  localparam logic [2:0] ST_WB     = 3'd2;
  localparam logic [2:0] ST_REFILL = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;
  localparam logic [2:0] ST_FSCAN  = 3'd5;
  localparam logic [2:0] ST_FWB    = 3'd6;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) begin
      r++;
    end
    return r;
  endfunction

endpackage

`define CACHE_FIELD(vec, hi, lo) vec[(hi):(lo)]

// File: rtl/cache_lru_ages.sv
// True-LRU helper for one set: age update on access, oldest way and lowest invalid way.
module cache_lru_ages #(
  parameter int unsigned WAYS = 4,
  parameter int unsigned AGEW = 2
) (
  input  logic [WAYS-1:0][AGEW-1:0] ages,
  input  logic [WAYS-1:0]           valid,
  input  logic [AGEW-1:0]           acc_way,
  output logic [WAYS-1:0][AGEW-1:0] ages_upd_c,
  output logic [AGEW-1:0]           lru_way_c,
  output logic [AGEW-1:0]           inv_way_c,
  output logic                      any_inv_c
);

  always_comb begin
    ages_upd_c = ages;
    lru_way_c  = '0;
    inv_way_c  = '0;
    any_inv_c  = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (ages[w] < ages[acc_way]) ages_upd_c[w] = AGEW'(ages[w] + 1'b1);
      if (ages[w] == AGEW'(WAYS - 1)) lru_way_c = AGEW'(w);
    end
    ages_upd_c[acc_way] = '0;
    // Descending scan leaves the lowest-numbered invalid way selected.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) begin
        inv_way_c = AGEW'(w);
        any_inv_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_nway_wb.sv
// N-way set-associative write-back, write-allocate cache controller with true-LRU replacement
// and a flush command; line state and data live in internal register arrays.
module cache_nway_wb
  import cache_pkg::*;
#(
  parameter int unsigned AWIDTH    = 16,
  parameter int unsigned DWIDTH    = 8,
  parameter int unsigned WAYS      = 4,
  parameter int unsigned SETS      = 8,
  parameter int unsigned BLOCKSIZE = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_cpu,
  input  logic              wr_cpu,
  input  logic              flush_cpu,
  input  logic [AWIDTH-1:0] addr_cpu,
  input  logic [DWIDTH-1:0] wdata_cpu,
  output logic [DWIDTH-1:0] rdata_cpu,
  output logic              ack_cpu,
  output logic              stall_cpu,
  output logic [AWIDTH-1:0] addr_mem,
  output logic              rd_mem,
  output logic              wr_mem,
  output logic [DWIDTH-1:0] wdata_mem,
  input  logic [DWIDTH-1:0] rdata_mem,
  input  logic              ready_mem
);

  localparam int unsigned OFFW = clog2(BLOCKSIZE);
  localparam int unsigned IDXW = clog2(SETS);
  localparam int unsigned TAGW = AWIDTH - IDXW - OFFW;
  localparam int unsigned AGEW = clog2(WAYS);
  localparam int unsigned CNTW = OFFW + 1;

  logic [ST_W-1:0]   state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [AGEW-1:0]   vic_q, vic_d, fway_q, fway_d;
  logic [IDXW-1:0]   fset_q, fset_d;
  logic              op_wr_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q;

  logic [TAGW-1:0]           tag_q   [SETS][WAYS];
  logic [WAYS-1:0]           valid_q [SETS];
  logic [WAYS-1:0]           dirty_q [SETS];
  logic [WAYS-1:0][AGEW-1:0] age_q   [SETS];
  logic [DWIDTH-1:0]         data_q  [SETS][WAYS][BLOCKSIZE];

  logic [TAGW-1:0]           tag_a;
  logic [IDXW-1:0]           idx_a, mset_c;
  logic [OFFW-1:0]           off_a, beat_q, beat_d;
  logic                      last_c, scan_end_c, fill_c, hit_c;
  logic [AGEW-1:0]           hit_way_c, acc_way_c, lru_way_c, inv_way_c, mway_c;
  logic                      any_inv_c;
  logic [WAYS-1:0][AGEW-1:0] ages_upd_c;
  logic                      rd_mem_d, wr_mem_d;
  logic [AWIDTH-1:0]         addr_mem_d;
  logic [DWIDTH-1:0]         wdata_mem_d;

  assign tag_a      = `CACHE_FIELD(addr_q, AWIDTH-1, IDXW+OFFW);
  assign idx_a      = `CACHE_FIELD(addr_q, IDXW+OFFW-1, OFFW);
  assign off_a      = `CACHE_FIELD(addr_q, OFFW-1, 0);
  assign beat_q     = cnt_q[OFFW-1:0];
  assign beat_d     = cnt_d[OFFW-1:0];
  assign last_c     = (cnt_q == CNTW'(BLOCKSIZE - 1));
  assign scan_end_c = (fset_q == IDXW'(SETS - 1)) && (fway_q == AGEW'(WAYS - 1));
  assign fill_c     = (state_q == ST_REFILL) && ready_mem && last_c;
  assign acc_way_c  = (state_q == ST_LOOKUP) ? hit_way_c : vic_q;

  // Tag compare across the indexed set.
  always_comb begin
    hit_c     = 1'b0;
    hit_way_c = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx_a][w] && (tag_q[idx_a][w] == tag_a)) begin
        hit_c     = 1'b1;
        hit_way_c = AGEW'(w);
      end
    end
  end

  cache_lru_ages #(.WAYS(WAYS), .AGEW(AGEW)) u_lru (
    .ages       (age_q[idx_a]),
    .valid      (valid_q[idx_a]),
    .acc_way    (acc_way_c),
    .ages_upd_c (ages_upd_c),
    .lru_way_c  (lru_way_c),
    .inv_way_c  (inv_way_c),
    .any_inv_c  (any_inv_c)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vic_d   = vic_q;
    fset_d  = fset_q;
    fway_d  = fway_q;
    case (state_q)
      ST_IDLE: begin
        if (rd_cpu || wr_cpu) begin
          state_d = ST_LOOKUP;
        end else if (flush_cpu) begin
          state_d = ST_FSCAN;
          fset_d  = '0;
          fway_d  = '0;
        end
      end
      ST_LOOKUP: begin
        if (hit_c) begin
          state_d = ST_DONE;
        end else begin
          vic_d   = any_inv_c ? inv_way_c : lru_way_c;
          cnt_d   = '0;
          state_d = (valid_q[idx_a][vic_d] && dirty_q[idx_a][vic_d]) ? ST_WB : ST_REFILL;
        end
      end
      ST_WB: begin
        if (ready_mem) begin
          cnt_d = last_c ? '0 : CNTW'(cnt_q + 1'b1);
          if (last_c) state_d = ST_REFILL;
        end
      end
      ST_REFILL: begin
        if (ready_mem) begin
          cnt_d = last_c ? '0 : CNTW'(cnt_q + 1'b1);
          if (last_c) state_d = ST_DONE;
        end
      end
      ST_FSCAN: begin
        cnt_d = '0;
        if (valid_q[fset_q][fway_q] && dirty_q[fset_q][fway_q]) begin
          state_d = ST_FWB;
        end else if (scan_end_c) begin
          state_d = ST_DONE;
        end else begin
          {fset_d, fway_d} = (IDXW + AGEW)'({fset_q, fway_q} + 1'b1);
        end
      end
      ST_FWB: begin
        if (ready_mem) begin
          cnt_d = last_c ? '0 : CNTW'(cnt_q + 1'b1);
          if (last_c) begin
            if (scan_end_c) begin
              state_d = ST_DONE;
            end else begin
              state_d          = ST_FSCAN;
              {fset_d, fway_d} = (IDXW + AGEW)'({fset_q, fway_q} + 1'b1);
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory-port values for the next cycle; registered so they hold while ready_mem is low.
  always_comb begin
    mset_c      = (state_d == ST_FWB) ? fset_d : idx_a;
    mway_c      = (state_d == ST_FWB) ? fway_d : vic_d;
    rd_mem_d    = (state_d == ST_REFILL);
    wr_mem_d    = (state_d == ST_WB) || (state_d == ST_FWB);
    addr_mem_d  = '0;
    wdata_mem_d = '0;
    if (wr_mem_d) begin
      addr_mem_d  = {tag_q[mset_c][mway_c], mset_c, beat_d};
      wdata_mem_d = data_q[mset_c][mway_c][beat_d];
    end else if (rd_mem_d) begin
      addr_mem_d = {tag_a, idx_a, beat_d};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      vic_q     <= '0;
      fset_q    <= '0;
      fway_q    <= '0;
      op_wr_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_cpu <= '0;
      ack_cpu   <= 1'b0;
      stall_cpu <= 1'b0;
      addr_mem  <= '0;
      rd_mem    <= 1'b0;
      wr_mem    <= 1'b0;
      wdata_mem <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= AGEW'(w);
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      vic_q     <= vic_d;
      fset_q    <= fset_d;
      fway_q    <= fway_d;
      ack_cpu   <= (state_d == ST_DONE);
      stall_cpu <= (state_d != ST_IDLE);
      rd_mem    <= rd_mem_d;
      wr_mem    <= wr_mem_d;
      addr_mem  <= addr_mem_d;
      wdata_mem <= wdata_mem_d;
      if ((state_q == ST_IDLE) && (rd_cpu || wr_cpu)) begin
        addr_q  <= addr_cpu;
        wdata_q <= wdata_cpu;
        op_wr_q <= !rd_cpu;
      end
      if ((state_q == ST_LOOKUP) && hit_c) begin
        age_q[idx_a] <= ages_upd_c;
        if (op_wr_q) dirty_q[idx_a][hit_way_c] <= 1'b1;
        else         rdata_cpu <= data_q[idx_a][hit_way_c][off_a];
      end
      if (fill_c) begin
        valid_q[idx_a][vic_q] <= 1'b1;
        dirty_q[idx_a][vic_q] <= op_wr_q;
        age_q[idx_a]          <= ages_upd_c;
        // The last beat is still on rdata_mem and not yet in the array.
        if (!op_wr_q) begin
          rdata_cpu <= (off_a == OFFW'(BLOCKSIZE - 1)) ? rdata_mem : data_q[idx_a][vic_q][off_a];
        end
      end
      if ((state_q == ST_FWB) && ready_mem && last_c) dirty_q[fset_q][fway_q] <= 1'b0;
    end
  end

  // Line data and tags need no reset: valid gates every use.
  always_ff @(posedge clock) begin
    if ((state_q == ST_LOOKUP) && hit_c && op_wr_q) data_q[idx_a][hit_way_c][off_a] <= wdata_q;
    if ((state_q == ST_REFILL) && ready_mem) begin
      data_q[idx_a][vic_q][beat_q] <= (op_wr_q && (beat_q == off_a)) ? wdata_q : rdata_mem;
    end
    if (fill_c) tag_q[idx_a][vic_q] <= tag_a;
  end

endmodule

// File: tb/tb_cache_nway_wb.sv
// Directed bench for cache_nway_wb: hits, misses, LRU eviction, write-back, memory stalls, flush, reset.
module tb_cache_nway_wb;

  logic        clock = 1'b0;
  logic        reset;
  logic        rd_cpu, wr_cpu, flush_cpu;
  logic [15:0] addr_cpu;
  logic [7:0]  wdata_cpu;
  logic [7:0]  rdata_cpu;
  logic        ack_cpu, stall_cpu;
  logic [15:0] addr_mem;
  logic        rd_mem, wr_mem;
  logic [7:0]  wdata_mem;
  logic [7:0]  rdata_mem;
  logic        ready_mem;

  int checks = 0;
  int errors = 0;

  logic [15:0] rd_addr_q [$];
  logic [15:0] wr_addr_q [$];
  logic [15:0] wr_data_q [$];
  logic [15:0] held_q    [$];
  int          hold_limit;
  int          both_high = 0;
  int          wdata_bad = 0;

  cache_nway_wb dut (
    .clock     (clock),
    .reset     (reset),
    .rd_cpu    (rd_cpu),
    .wr_cpu    (wr_cpu),
    .flush_cpu (flush_cpu),
    .addr_cpu  (addr_cpu),
    .wdata_cpu (wdata_cpu),
    .rdata_cpu (rdata_cpu),
    .ack_cpu   (ack_cpu),
    .stall_cpu (stall_cpu),
    .addr_mem  (addr_mem),
    .rd_mem    (rd_mem),
    .wr_mem    (wr_mem),
    .wdata_mem (wdata_mem),
    .rdata_mem (rdata_mem),
    .ready_mem (ready_mem)
  );

  always #5 clock = ~clock;

  // Memory image: line 0x1234..0x1237 holds A0..A3, every other byte is its low address byte.
  assign rdata_mem = (addr_mem[15:2] == 14'h048D) ? (8'hA0 + {6'd0, addr_mem[1:0]}) : addr_mem[7:0];

  always @(posedge clock) begin
    if (rd_mem && wr_mem) both_high++;
    if (!wr_mem && (wdata_mem != 8'h00)) wdata_bad++;
    if (ready_mem && wr_mem) begin
      wr_addr_q.push_back(addr_mem);
      wr_data_q.push_back({8'h00, wdata_mem});
    end
    if (ready_mem && rd_mem) rd_addr_q.push_back(addr_mem);
  end

  always @(negedge clock) begin
    if ((held_q.size() < hold_limit) && rd_mem && (addr_mem[1:0] == 2'd2)) begin
      ready_mem = 1'b0;
      held_q.push_back(addr_mem);
    end else begin
      ready_mem = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] q_at(input logic [15:0] q [$], input int i);
    return (i < q.size()) ? q[i] : 16'hFFFF;
  endfunction

  // op: 0 read, 1 write, 2 flush, 3 read+write together. lat counts edges from acceptance (1) to ack.
  task automatic do_req(input int op, input logic [15:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output int lat);
    @(negedge clock);
    for (int i = 0; i < 4 && stall_cpu; i++) @(negedge clock);
    addr_cpu  = a;
    wdata_cpu = d;
    rd_cpu    = (op == 0) || (op == 3);
    wr_cpu    = (op == 1) || (op == 3);
    flush_cpu = (op == 2);
    lat = 0;
    rd  = 8'h00;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clock);
      #1;
      if (k == 1) begin
        rd_cpu    = 1'b0;
        wr_cpu    = 1'b0;
        flush_cpu = 1'b0;
        addr_cpu  = 16'hFFFF;
        wdata_cpu = 8'hFF;
      end
      if (ack_cpu) begin
        lat = k;
        rd  = rdata_cpu;
        break;
      end
    end
    check("ack_seen", 32'(lat != 0), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  logic [7:0] rd;
  int lat, rb, wb, hb;
  logic found;

  initial begin
    reset = 1'b1; rd_cpu = 1'b0; wr_cpu = 1'b0; flush_cpu = 1'b0;
    addr_cpu = '0; wdata_cpu = '0; hold_limit = 0;
    repeat (2) @(negedge clock);
    check("rst_ack",   ack_cpu,   0);
    check("rst_stall", stall_cpu, 0);
    check("rst_rdmem", rd_mem,    0);
    check("rst_wrmem", wr_mem,    0);
    check("rst_addr",  addr_mem,  0);
    check("rst_rdata", rdata_cpu, 0);
    reset = 1'b0;

    // 1: cold read miss then hit
    rb = rd_addr_q.size(); wb = wr_addr_q.size();
    do_req(0, 16'h1236, 8'h00, rd, lat);
    check("t1_rdata",    rd, 8'hA2);
    check("t1_rbeats",   rd_addr_q.size() - rb, 4);
    check("t1_rfirst",   q_at(rd_addr_q, rb), 16'h1234);
    check("t1_rlast",    q_at(rd_addr_q, rb + 3), 16'h1237);
    check("t1_wbeats",   wr_addr_q.size() - wb, 0);
    check("t1_misslat",  lat, 6);
    rb = rd_addr_q.size();
    do_req(0, 16'h1235, 8'h00, rd, lat);
    check("t1_hitdata",  rd, 8'hA1);
    check("t1_hitlat",   lat, 2);
    check("t1_hitbeats", rd_addr_q.size() - rb, 0);

    // 2: dirty line becomes LRU and is written back before the refill
    rb = rd_addr_q.size(); wb = wr_addr_q.size();
    do_req(1, 16'h1235, 8'h55, rd, lat);
    check("t2_wrhitlat", lat, 2);
    check("t2_wrbeats",  (rd_addr_q.size() - rb) + (wr_addr_q.size() - wb), 0);
    do_req(0, 16'h1254, 8'h00, rd, lat);
    check("t2_r1254", rd, 8'h54);
    do_req(0, 16'h1274, 8'h00, rd, lat);
    do_req(0, 16'h1294, 8'h00, rd, lat);
    rb = rd_addr_q.size(); wb = wr_addr_q.size();
    do_req(0, 16'h12B4, 8'h00, rd, lat);
    check("t2_wbcount", wr_addr_q.size() - wb, 4);
    check("t2_wba0",    q_at(wr_addr_q, wb), 16'h1234);
    check("t2_wba3",    q_at(wr_addr_q, wb + 3), 16'h1237);
    check("t2_wbd0",    q_at(wr_data_q, wb), 16'h00A0);
    check("t2_wbd1",    q_at(wr_data_q, wb + 1), 16'h0055);
    check("t2_wbd2",    q_at(wr_data_q, wb + 2), 16'h00A2);
    check("t2_wbd3",    q_at(wr_data_q, wb + 3), 16'h00A3);
    check("t2_rfcount", rd_addr_q.size() - rb, 4);
    check("t2_rffirst", q_at(rd_addr_q, rb), 16'h12B4);
    check("t2_rdata",   rd, 8'hB4);

    // 3: LRU victim after touching A is B, clean so no write-back
    do_reset();
    do_req(0, 16'h1234, 8'h00, rd, lat);
    do_req(0, 16'h1254, 8'h00, rd, lat);
    do_req(0, 16'h1274, 8'h00, rd, lat);
    do_req(0, 16'h1294, 8'h00, rd, lat);
    do_req(0, 16'h1234, 8'h00, rd, lat);
    check("t3_hitA", lat, 2);
    rb = rd_addr_q.size(); wb = wr_addr_q.size();
    do_req(0, 16'h12B4, 8'h00, rd, lat);
    check("t3_nowb",   wr_addr_q.size() - wb, 0);
    check("t3_refill", rd_addr_q.size() - rb, 4);
    do_req(0, 16'h1234, 8'h00, rd, lat);
    check("t3_Astill", lat, 2);
    check("t3_Adata",  rd, 8'hA0);
    rb = rd_addr_q.size();
    do_req(0, 16'h1254, 8'h00, rd, lat);
    check("t3_Bgone",  rd_addr_q.size() - rb, 4);

    // 4: memory holds off refill beat 2 for three cycles
    do_reset();
    rb = rd_addr_q.size(); hb = held_q.size();
    hold_limit = hb + 3;
    do_req(0, 16'h1236, 8'h00, rd, lat);
    check("t4_rdata",  rd, 8'hA2);
    check("t4_lat",    lat, 9);
    check("t4_beats",  rd_addr_q.size() - rb, 4);
    check("t4_b2addr", q_at(rd_addr_q, rb + 2), 16'h1236);
    check("t4_b3addr", q_at(rd_addr_q, rb + 3), 16'h1237);
    check("t4_nheld",  held_q.size() - hb, 3);
    check("t4_held0",  q_at(held_q, hb), 16'h1236);
    check("t4_held2",  q_at(held_q, hb + 2), 16'h1236);
    do_req(0, 16'h1237, 8'h00, rd, lat);
    check("t4_w3", rd, 8'hA3);
    do_req(0, 16'h1234, 8'h00, rd, lat);
    check("t4_w0", rd, 8'hA0);

    // 5: flush writes back set 1 then set 6; a second flush is empty
    do_reset();
    do_req(1, 16'h0105, 8'h77, rd, lat);
    do_req(1, 16'h021A, 8'h88, rd, lat);
    rb = rd_addr_q.size(); wb = wr_addr_q.size();
    do_req(2, 16'h0000, 8'h00, rd, lat);
    check("t5_count", wr_addr_q.size() - wb, 8);
    check("t5_a0",    q_at(wr_addr_q, wb), 16'h0104);
    check("t5_a3",    q_at(wr_addr_q, wb + 3), 16'h0107);
    check("t5_a4",    q_at(wr_addr_q, wb + 4), 16'h0218);
    check("t5_d0",    q_at(wr_data_q, wb), 16'h0004);
    check("t5_d1",    q_at(wr_data_q, wb + 1), 16'h0077);
    check("t5_d6",    q_at(wr_data_q, wb + 6), 16'h0088);
    check("t5_d7",    q_at(wr_data_q, wb + 7), 16'h001B);
    check("t5_noread", rd_addr_q.size() - rb, 0);
    wb = wr_addr_q.size();
    do_req(2, 16'h0000, 8'h00, rd, lat);
    check("t5_empty", wr_addr_q.size() - wb, 0);
    do_req(0, 16'h0105, 8'h00, rd, lat);
    check("t5_keptvalid", lat, 2);
    check("t5_keptdata",  rd, 8'h77);

    // 6: asynchronous reset in the middle of a refill
    do_reset();
    @(negedge clock);
    addr_cpu = 16'h1236; rd_cpu = 1'b1;
    @(posedge clock);
    #1 rd_cpu = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (rd_mem && (addr_mem == 16'h1236)) begin
        found = 1'b1;
        break;
      end
    end
    check("t6_reach", found, 1);
    #2 reset = 1'b1;
    #1;
    check("t6_rdmem", rd_mem,    0);
    check("t6_stall", stall_cpu, 0);
    check("t6_addr",  addr_mem,  0);
    @(negedge clock);
    reset = 1'b0;
    rb = rd_addr_q.size();
    do_req(0, 16'h1236, 8'h00, rd, lat);
    check("t6_remiss", rd_addr_q.size() - rb, 4);
    check("t6_rdata",  rd, 8'hA2);

    // 7: simultaneous read and write: read wins, line stays clean
    do_reset();
    rb = rd_addr_q.size();
    do_req(3, 16'h0309, 8'hEE, rd, lat);
    check("t7_rdata", rd, 8'h09);
    check("t7_fill",  rd_addr_q.size() - rb, 4);
    wb = wr_addr_q.size();
    do_req(2, 16'h0000, 8'h00, rd, lat);
    check("t7_clean", wr_addr_q.size() - wb, 0);
    do_req(0, 16'h0309, 8'h00, rd, lat);
    check("t7_hit",   lat, 2);
    check("t7_data",  rd, 8'h09);

    check("never_both",  both_high, 0);
    check("wdata_quiet", wdata_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
